// File: rtl/dual_port_mem_responder.sv
// dual_port_mem_responder: responder end of a CPU's instruction (A, read-only)
// and data (B, read/write) memory ports. Each port runs its own
// IDLE -> BUSY -> RESP FSM and answers after a fixed per-port latency with a
// one-cycle resp pulse. Both ports share one word-addressed 16-bit array.
// Optional build macro MEM_STATS_EN adds read/write statistics counters.
module dual_port_mem_responder #(
    parameter int ADDR_W    = 8,
    parameter int LATENCY_A = 2,
    parameter int LATENCY_B = 3
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        read_a,
    input  logic [15:0] address_a,
    output logic        resp_a,
    output logic [15:0] rdata_a,
    input  logic        read_b,
    input  logic        write_b,
    input  logic [15:0] address_b,
    input  logic [15:0] wdata_b,
    output logic        resp_b,
    output logic [15:0] rdata_b
`ifdef MEM_STATS_EN
    ,
    output logic [31:0] stat_reads,
    output logic [31:0] stat_writes
`endif
);

    localparam int DEPTH = 1 << ADDR_W;
    localparam logic [3:0] LOAD_A = 4'(LATENCY_A - 1);
    localparam logic [3:0] LOAD_B = 4'(LATENCY_B - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t            state_a_q, state_a_d;
    state_t            state_b_q, state_b_d;
    logic [3:0]        cnt_a_q, cnt_a_d;
    logic [3:0]        cnt_b_q, cnt_b_d;
    logic [15:0]       mem [DEPTH];

    logic [ADDR_W-1:0] idx_a;
    logic [ADDR_W-1:0] idx_b;
    logic              req_b;
    logic              wr_b_q;
    logic [ADDR_W-1:0] addr_b_q;
    logic [15:0]       wdata_b_q;
    logic              sample_a;
    logic              sample_b;
    logic              commit_b;

    // Address bits above the word index and the byte-select bit are ignored.
    logic              unused_addr_bits;
    assign unused_addr_bits = ^{address_a[15:ADDR_W+1], address_a[0],
                                address_b[15:ADDR_W+1], address_b[0]};

    assign idx_a = address_a[ADDR_W:1];
    assign idx_b = address_b[ADDR_W:1];
    assign req_b = read_b | write_b;

    // Port A state and latency counter register.
    always_ff @(posedge clk or posedge reset) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples pre-edge values regardless of statement order.
        if (reset) begin
            state_a_q <= IDLE;
            cnt_a_q   <= '0;
        end else begin
            state_a_q <= state_a_d;
            cnt_a_q   <= cnt_a_d;
        end
    end

    // Port A next state, counter and resp decode; a dropped request aborts.
    always_comb begin
        // NOTE: defaults first so no path leaves a variable unassigned,
        // which would otherwise infer a latch.
        state_a_d = state_a_q;
        cnt_a_d   = cnt_a_q;
        resp_a    = 1'b0;
        sample_a  = 1'b0;
        case (state_a_q)
            IDLE: begin
                if (read_a) begin
                    state_a_d = BUSY;
                    cnt_a_d   = LOAD_A;
                end
            end
            BUSY: begin
                if (!read_a) begin
                    state_a_d = IDLE;
                    cnt_a_d   = '0;
                end else if (cnt_a_q == 4'd0) begin
                    state_a_d = RESP;
                    sample_a  = 1'b1;
                end else begin
                    cnt_a_d = cnt_a_q - 4'd1;
                end
            end
            RESP: begin
                resp_a    = 1'b1;
                state_a_d = IDLE;
            end
            default: state_a_d = IDLE;
        endcase
    end

    // Port B state, counter and per-edge capture of op/address/data.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_b_q <= IDLE;
            cnt_b_q   <= '0;
            wr_b_q    <= 1'b0;
            addr_b_q  <= '0;
            wdata_b_q <= '0;
        end else begin
            state_b_q <= state_b_d;
            cnt_b_q   <= cnt_b_d;
            if ((state_b_q == IDLE && req_b) || state_b_q == BUSY) begin
                wr_b_q    <= write_b;
                addr_b_q  <= idx_b;
                wdata_b_q <= wdata_b;
            end
        end
    end

    // Port B next state, counter, resp decode and write-commit strobe.
    always_comb begin
        state_b_d = state_b_q;
        cnt_b_d   = cnt_b_q;
        resp_b    = 1'b0;
        sample_b  = 1'b0;
        commit_b  = 1'b0;
        case (state_b_q)
            IDLE: begin
                if (req_b) begin
                    state_b_d = BUSY;
                    cnt_b_d   = LOAD_B;
                end
            end
            BUSY: begin
                if (!req_b) begin
                    state_b_d = IDLE;
                    cnt_b_d   = '0;
                end else if (cnt_b_q == 4'd0) begin
                    state_b_d = RESP;
                    sample_b  = !write_b;
                end else begin
                    cnt_b_d = cnt_b_q - 4'd1;
                end
            end
            RESP: begin
                resp_b    = 1'b1;
                commit_b  = req_b && wr_b_q;
                state_b_d = IDLE;
            end
            default: state_b_d = IDLE;
        endcase
    end

    // Shared array: only port B writes, committing as it leaves RESP.
    always_ff @(posedge clk or posedge reset) begin
        // NOTE: the array is reset explicitly because cleared contents are
        // architecturally visible; this rules out block-RAM mapping.
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (commit_b) begin
            mem[addr_b_q] <= wdata_b_q;
        end
    end

    // Read data is captured entering RESP and is zero in every other cycle;
    // a same-edge write is not yet visible, giving read-before-write.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rdata_a <= '0;
            rdata_b <= '0;
        end else begin
            rdata_a <= sample_a ? mem[idx_a] : 16'h0000;
            rdata_b <= sample_b ? mem[idx_b] : 16'h0000;
        end
    end

`ifdef MEM_STATS_EN
    // Statistics: reads counted per read resp, writes per committed write.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stat_reads  <= '0;
            stat_writes <= '0;
        end else begin
            stat_reads  <= stat_reads + 32'(resp_a) + 32'(resp_b && !wr_b_q);
            stat_writes <= stat_writes + 32'(commit_b);
        end
    end
`endif

endmodule

// File: tb/tb_dual_port_mem_responder.sv
// Self-checking bench for dual_port_mem_responder: a bench-side memory model
// feeds per-port expected-data queues, popped when each resp arrives.
module tb_dual_port_mem_responder;

    localparam int ADDR_W = 8;
    localparam int LAT_A  = 2;
    localparam int LAT_B  = 3;
    localparam int BOUND  = 20;

    logic        clk;
    logic        reset;
    logic        read_a;
    logic [15:0] address_a;
    logic        resp_a;
    logic [15:0] rdata_a;
    logic        read_b;
    logic        write_b;
    logic [15:0] address_b;
    logic [15:0] wdata_b;
    logic        resp_b;
    logic [15:0] rdata_b;
`ifdef MEM_STATS_EN
    logic [31:0] stat_reads;
    logic [31:0] stat_writes;
`endif

    int checks = 0;
    int errors = 0;
    int exp_reads = 0;
    int exp_writes = 0;

    logic [15:0] model [1 << ADDR_W];
    logic [15:0] q_a [$];
    logic [15:0] q_b [$];

    dual_port_mem_responder #(
        .ADDR_W(ADDR_W),
        .LATENCY_A(LAT_A),
        .LATENCY_B(LAT_B)
    ) dut (
        .clk(clk),
        .reset(reset),
        .read_a(read_a),
        .address_a(address_a),
        .resp_a(resp_a),
        .rdata_a(rdata_a),
        .read_b(read_b),
        .write_b(write_b),
        .address_b(address_b),
        .wdata_b(wdata_b),
        .resp_b(resp_b),
        .rdata_b(rdata_b)
`ifdef MEM_STATS_EN
        ,
        .stat_reads(stat_reads),
        .stat_writes(stat_writes)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int word_of(input logic [15:0] addr);
        return int'(addr[ADDR_W:1]);
    endfunction

    task automatic clear_model();
        for (int i = 0; i < (1 << ADDR_W); i++) model[i] = 16'h0000;
    endtask

    // One port A read; called just after a negedge.
    task automatic do_a(input logic [15:0] addr);
        int n;
        bit seen;
        logic [15:0] exp;
        q_a.push_back(model[word_of(addr)]);
        address_a = addr;
        read_a = 1'b1;
        n = 0;
        seen = 0;
        while (!seen && n < BOUND) begin
            @(negedge clk);
            n++;
            if (resp_a === 1'b1) seen = 1;
        end
        checks++;
        if (!seen) begin
            $display("FAIL a_timeout addr=%h: no resp_a after %0d cycles", addr, n);
            errors++;
            void'(q_a.pop_front());
        end else begin
            if (n != LAT_A + 1) begin
                $display("FAIL a_latency addr=%h: got %0d cycles, want %0d", addr, n, LAT_A + 1);
                errors++;
            end
            exp = q_a.pop_front();
            checks++;
            if (rdata_a !== exp) begin
                $display("FAIL a_rdata addr=%h: got %h, want %h", addr, rdata_a, exp);
                errors++;
            end
            exp_reads++;
        end
        @(posedge clk);
        #1 read_a = 1'b0;
        @(negedge clk);
        checks++;
        if (resp_a !== 1'b0 || rdata_a !== 16'h0000) begin
            $display("FAIL a_pulse addr=%h: resp=%b rdata=%h, want 0/0000", addr, resp_a, rdata_a);
            errors++;
        end
    endtask

    // One port B transaction (wr=1 write, else read); called just after a negedge.
    task automatic do_b(input logic wr, input logic [15:0] addr, input logic [15:0] data);
        int n;
        bit seen;
        logic [15:0] exp;
        if (!wr) q_b.push_back(model[word_of(addr)]);
        address_b = addr;
        wdata_b = data;
        write_b = wr;
        read_b = !wr;
        n = 0;
        seen = 0;
        while (!seen && n < BOUND) begin
            @(negedge clk);
            n++;
            if (resp_b === 1'b1) seen = 1;
        end
        checks++;
        if (!seen) begin
            $display("FAIL b_timeout addr=%h: no resp_b after %0d cycles", addr, n);
            errors++;
            if (!wr) void'(q_b.pop_front());
        end else begin
            if (n != LAT_B + 1) begin
                $display("FAIL b_latency addr=%h: got %0d cycles, want %0d", addr, n, LAT_B + 1);
                errors++;
            end
            if (!wr) begin
                exp = q_b.pop_front();
                checks++;
                if (rdata_b !== exp) begin
                    $display("FAIL b_rdata addr=%h: got %h, want %h", addr, rdata_b, exp);
                    errors++;
                end
                exp_reads++;
            end
        end
        @(posedge clk);
        if (wr && seen) begin
            model[word_of(addr)] = data;
            exp_writes++;
        end
        #1;
        write_b = 1'b0;
        read_b = 1'b0;
        @(negedge clk);
        checks++;
        if (resp_b !== 1'b0 || rdata_b !== 16'h0000) begin
            $display("FAIL b_pulse addr=%h: resp=%b rdata=%h, want 0/0000", addr, resp_b, rdata_b);
            errors++;
        end
    endtask

    task automatic check_stats(input string tag);
`ifdef MEM_STATS_EN
        checks++;
        if (stat_reads !== 32'(exp_reads) || stat_writes !== 32'(exp_writes)) begin
            $display("FAIL stats_%s: reads=%0d writes=%0d, want %0d/%0d", tag,
                     stat_reads, stat_writes, exp_reads, exp_writes);
            errors++;
        end
`else
        if (tag.len() < 0) $display("%s", tag);
`endif
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        checks++;
        if (resp_a !== 1'b0 || resp_b !== 1'b0 || rdata_a !== 16'h0000 || rdata_b !== 16'h0000) begin
            $display("FAIL reset_outputs: resp_a=%b resp_b=%b rdata_a=%h rdata_b=%h, want all 0",
                     resp_a, resp_b, rdata_a, rdata_b);
            errors++;
        end
        check_stats("reset");
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_read_a();
        do_a(16'h0010);
    endtask

    task automatic test_write_read_b();
        do_b(1'b1, 16'h0020, 16'hBEEF);
        do_b(1'b0, 16'h0021, 16'h0000);
    endtask

    task automatic test_alias();
        do_b(1'b1, 16'h0002, 16'h1234);
        do_a(16'h0202);
    endtask

    // A samples 0x0040 on the same edge the B write to 0x0040 commits.
    task automatic test_read_before_write();
        fork
            do_b(1'b1, 16'h0040, 16'h5555);
            begin
                repeat (2) @(negedge clk);
                do_a(16'h0040);
            end
        join
        do_a(16'h0040);
        check_stats("rbw");
    endtask

    task automatic test_abort();
        bit seen;
        address_b = 16'h0080;
        wdata_b = 16'hDEAD;
        write_b = 1'b1;
        repeat (2) @(negedge clk);
        write_b = 1'b0;
        seen = 0;
        repeat (8) begin
            @(negedge clk);
            if (resp_b === 1'b1) seen = 1;
        end
        checks++;
        if (seen) begin
            $display("FAIL abort_resp: resp_b seen=1, want 0");
            errors++;
        end
        do_b(1'b0, 16'h0080, 16'h0000);
        do_b(1'b1, 16'h0080, 16'hCAFE);
        do_b(1'b0, 16'h0080, 16'h0000);
        check_stats("abort");
    endtask

    task automatic test_reset_mid();
        int n;
        do_b(1'b1, 16'h0060, 16'h7777);
        read_a = 1'b1;
        address_a = 16'h0060;
        write_b = 1'b1;
        address_b = 16'h0062;
        wdata_b = 16'h9999;
        n = 0;
        while (resp_a !== 1'b1 && n < BOUND) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (rdata_a !== 16'h7777) begin
            $display("FAIL rst_pre_rdata: got %h, want 7777", rdata_a);
            errors++;
        end
        #1 reset = 1'b1;
        #1;
        checks++;
        if (resp_a !== 1'b0 || resp_b !== 1'b0 || rdata_a !== 16'h0000 || rdata_b !== 16'h0000) begin
            $display("FAIL rst_mid_outputs: resp_a=%b resp_b=%b rdata_a=%h rdata_b=%h, want all 0",
                     resp_a, resp_b, rdata_a, rdata_b);
            errors++;
        end
        read_a = 1'b0;
        write_b = 1'b0;
        clear_model();
        exp_reads = 0;
        exp_writes = 0;
        check_stats("rst_mid");
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        do_a(16'h0060);
        do_b(1'b0, 16'h0062, 16'h0000);
        do_a(16'h0020);
        check_stats("post_rst");
    endtask

    initial begin
        reset = 1'b1;
        read_a = 1'b0;
        address_a = '0;
        read_b = 1'b0;
        write_b = 1'b0;
        address_b = '0;
        wdata_b = '0;
        clear_model();
        test_reset();
        test_read_a();
        test_write_read_b();
        test_alias();
        test_read_before_write();
        test_abort();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
